// File: rtl/conv_pkg.sv
// conv_pkg: shared types, widths and clamp helper for the 3x3 convolution MAC stage.
package conv_pkg;
    localparam int KSIZE  = 9;
    localparam int PROD_W = 17;
    localparam int ACC_W  = 21;
    typedef logic signed [7:0]        coef_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic        [7:0]        pix_t;
    function automatic pix_t clamp_u8(input acc_t v);
        return v[ACC_W-1] ? 8'h00 : (v > acc_t'(255)) ? 8'hFF : v[7:0];
    endfunction
endpackage

// File: rtl/conv_kernel_regs.sv
// conv_kernel_regs: nine signed kernel coefficients, reset to an identity kernel scaled by 2**SHIFT.
module conv_kernel_regs
    import conv_pkg::*;
#(
    parameter int SHIFT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [3:0] addr,
    input  coef_t      data,
    output coef_t      coef [KSIZE]
);
    localparam coef_t ID = (SHIFT >= 7) ? coef_t'(127) : coef_t'(1 << SHIFT);
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < KSIZE; k++) coef[k] <= (k == 4) ? ID : '0;
        end else if (we && addr < 4'(KSIZE)) begin
            coef[addr] <= data;
        end
    end
endmodule

// File: rtl/conv3x3_mac_stage.sv
// conv3x3_mac_stage: 3-stage 3x3 convolution (multiply, adder tree, shift/round/clamp) with frame position tracking.
// Define CONV_ABS_EN to clamp |r| instead of r (edge-magnitude mode).
module conv3x3_mac_stage
    import conv_pkg::*;
#(
    parameter int N     = 32,
    parameter int SHIFT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_load,
    input  logic [71:0] window,
    input  logic        frame_start,
    input  logic        coef_we,
    input  logic [3:0]  coef_addr,
    input  logic [7:0]  coef_data,
    output logic [7:0]  pix_o,
    output logic        valid_o,
    output logic        frame_done_o
);
    localparam int   CW   = $clog2(N);
    localparam acc_t BIAS = acc_t'((1 << SHIFT) >> 1);
    logic [CW-1:0] col, row;
    logic          ld_d, in_frame_d, s1_v, s1_in, s2_v, s2_in, last;
    coef_t         coef [KSIZE];
    prod_t         p    [KSIZE];
    acc_t          sum, sum_c, r, mag;
    conv_kernel_regs #(.SHIFT(SHIFT)) u_coef (
        .clk  (clk),
        .rst  (rst),
        .we   (coef_we),
        .addr (coef_addr),
        .data (coef_t'(coef_data)),
        .coef (coef)
    );
    assign last = (col == CW'(N-1)) && (row == CW'(N-1));
    always_comb begin
        sum_c = '0;
        for (int k = 0; k < KSIZE; k++) sum_c = sum_c + acc_t'(p[k]);
        r = (sum + BIAS) >>> SHIFT;
`ifdef CONV_ABS_EN
        mag = r[ACC_W-1] ? -r : r;
`else
        mag = r;
`endif
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            col          <= '0;
            row          <= '0;
            ld_d         <= 1'b0;
            in_frame_d   <= 1'b0;
            s1_v         <= 1'b0;
            s1_in        <= 1'b0;
            s2_v         <= 1'b0;
            s2_in        <= 1'b0;
            for (int k = 0; k < KSIZE; k++) p[k] <= '0;
            sum          <= '0;
            pix_o        <= '0;
            valid_o      <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            if (frame_start) begin
                col <= '0;
                row <= '0;
            end else if (data_load) begin
                col <= (col == CW'(N-1)) ? '0 : col + 1'b1;
                if (col == CW'(N-1)) row <= last ? '0 : row + 1'b1;
            end
            frame_done_o <= data_load && !frame_start && last;
            // The window stage updates on the load edge, so its output is valid one cycle later.
            ld_d       <= data_load && !frame_start;
            in_frame_d <= (row >= CW'(2)) && (col >= CW'(2));
            s1_v       <= ld_d;
            if (ld_d) begin
                s1_in <= in_frame_d;
                for (int k = 0; k < KSIZE; k++)
                    p[k] <= prod_t'($signed({1'b0, window[8*k +: 8]})) * prod_t'(coef[k]);
            end
            s2_v    <= s1_v;
            s2_in   <= s1_in;
            sum     <= sum_c;
            valid_o <= s2_v && s2_in;
            if (s2_v && s2_in) pix_o <= clamp_u8(mag);
        end
    end
endmodule

// File: tb/tb_conv3x3_mac_stage.sv
// tb_conv3x3_mac_stage: directed and randomized checks of conv3x3_mac_stage against a frame-level reference model.
module tb_conv3x3_mac_stage;
    localparam int N     = 4;
    localparam int SHIFT = 4;
    logic        clk = 1'b0, rst = 1'b0, data_load = 1'b0, frame_start = 1'b0, coef_we = 1'b0;
    logic [71:0] window = '0;
    logic [3:0]  coef_addr = '0;
    logic [7:0]  coef_data = '0;
    logic [7:0]  pix_o;
    logic        valid_o, frame_done_o;
    int tests = 0, fails = 0, e = 0, pos = 0, pix_m = 0, vcnt = 0, fdcnt = 0;
    int coef_m [9];
    bit exp_v  [int];
    int exp_p  [int];
    bit exp_fd [int];
    int obs_q  [$];
    int ramp_exp [4] = '{5, 6, 9, 10};

    conv3x3_mac_stage #(.N(N), .SHIFT(SHIFT)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_load    (data_load),
        .window       (window),
        .frame_start  (frame_start),
        .coef_we      (coef_we),
        .coef_addr    (coef_addr),
        .coef_data    (coef_data),
        .pix_o        (pix_o),
        .valid_o      (valid_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_pix(input logic [71:0] w);
        int s = 0;
        for (int k = 0; k < 9; k++) s += int'(w[8*k +: 8]) * coef_m[k];
        s = (s + ((1 << SHIFT) >> 1)) >>> SHIFT;
`ifdef CONV_ABS_EN
        if (s < 0) s = -s;
`endif
        return (s < 0) ? 0 : (s > 255) ? 255 : s;
    endfunction

    function automatic logic [71:0] ramp_win(input int p);
        logic [71:0] w = '0;
        for (int rr = 0; rr < 3; rr++)
            for (int cc = 0; cc < 3; cc++) begin
                int ri = p / N - rr, ci = p % N - cc;
                int v = (ri >= 0 && ci >= 0) ? ri * N + ci : 0;
                w[8*(3*rr+cc) +: 8] = 8'(v);
            end
        return w;
    endfunction

    task automatic tick(input logic rn, ld, fs, we, input logic [3:0] a, input logic [7:0] d, input logic [71:0] w);
        rst = rn; data_load = ld; frame_start = fs; coef_we = we; coef_addr = a; coef_data = d;
        @(posedge clk);
        e++;
        if (!rn) begin
            exp_v.delete(); exp_p.delete(); exp_fd.delete();
            pix_m = 0; pos = 0;
            foreach (coef_m[k]) coef_m[k] = 0;
            coef_m[4] = (SHIFT >= 7) ? 127 : (1 << SHIFT);
        end else begin
            if (we && a < 9) coef_m[a] = int'($signed(d));
            if (fs) pos = 0;
            else if (ld) begin
                if (pos / N >= 2 && pos % N >= 2) begin
                    exp_v[e+3] = 1'b1;
                    exp_p[e+3] = ref_pix(w);
                end
                if (pos == N*N-1) exp_fd[e] = 1'b1;
                pos = (pos + 1) % (N*N);
            end
        end
        #1;
        window = w;
        if (exp_v.exists(e)) pix_m = exp_p[e];
        chk("valid", valid_o, exp_v.exists(e));
        chk("pix", pix_o, pix_m);
        chk("frame_done", frame_done_o, exp_fd.exists(e));
        if (valid_o) begin vcnt++; obs_q.push_back(int'(pix_o)); end
        if (frame_done_o) fdcnt++;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, window);
    endtask

    task automatic wr(input int a, input int v);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 4'(a), 8'(v), window);
    endtask

    task automatic set_all(input int v);
        for (int k = 0; k < 9; k++) wr(k, v);
    endtask

    task automatic frame(input int mode, input int val, input bit gaps);
        logic [71:0] w;
        for (int p = 0; p < N*N; p++) begin
            if (mode == 0) w = ramp_win(p);
            else if (mode == 1) w = {9{8'(val)}};
            else begin
                w[31:0] = $urandom(); w[63:32] = $urandom(); w[71:64] = 8'($urandom());
            end
            if (gaps)
                while ($urandom_range(0, 2) == 0)
                    tick(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 4'($urandom()), 8'($urandom()), window);
            tick(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0, w);
        end
    endtask

    initial begin
        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, '0);
        obs_q.delete(); vcnt = 0; fdcnt = 0;
        frame(0, 0, 1'b0);
        idle(5);
        chk("ramp_count", obs_q.size(), 4);
        for (int i = 0; i < 4; i++) chk("ramp_pix", (i < obs_q.size()) ? obs_q[i] : -1, ramp_exp[i]);
        chk("ramp_frame_done", fdcnt, 1);
        set_all(16);
        frame(1, 200, 1'b0);
        idle(5);
        chk("clamp_high", pix_o, 255);
        set_all(0);
        wr(0, -16);
        frame(1, 50, 1'b0);
        idle(5);
`ifdef CONV_ABS_EN
        chk("negative_abs", pix_o, 50);
`else
        chk("negative_clamp", pix_o, 0);
`endif
        set_all(0);
        wr(4, 8);
        frame(1, 3, 1'b0);
        idle(5);
        chk("round_half_up", pix_o, 2);
        frame(2, 0, 1'b0);
        vcnt = 0;
        tick(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, window);
        idle(5);
        chk("reset_drops_inflight", vcnt, 0);
        vcnt = 0;
        frame(1, 77, 1'b0);
        idle(5);
        chk("reset_identity", pix_o, 77);
        chk("post_reset_frame_count", vcnt, (N-2)*(N-2));
        for (int p = 0; p < 10; p++) tick(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0, ramp_win(p));
        vcnt = 0;
        tick(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 8'd0, ramp_win(10));
        idle(5);
        chk("frame_start_drop", vcnt, 0);
        vcnt = 0; fdcnt = 0;
        frame(0, 0, 1'b0);
        idle(5);
        chk("frame_start_frame_count", vcnt, (N-2)*(N-2));
        chk("frame_start_frame_done", fdcnt, 1);
        vcnt = 0;
        repeat (4) frame(2, 0, 1'b1);
        idle(5);
        chk("random_frame_count", vcnt, 4*(N-2)*(N-2));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
